// File: rtl/stoch_signed_nselect.sv
// Signed stochastic N-way max/min selector: tracks each bipolar (p/m) stream with a
// saturating up/down counter and forwards the stream whose counter is currently extreme.
module stoch_signed_nselect #(
    parameter int NUM_INPUTS   = 2,
    parameter int COUNTER_SIZE = 8,
    parameter int WARMUP       = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          en,
    input  logic                          find_min,
    input  logic [NUM_INPUTS-1:0]         as_p,
    input  logic [NUM_INPUTS-1:0]         as_m,
    output logic                          y_p,
    output logic                          y_m,
    output logic [$clog2(NUM_INPUTS)-1:0] sel_idx,
    output logic                          out_valid
);

    localparam int SW = $clog2(NUM_INPUTS);
    localparam int WW = $clog2(WARMUP + 1);
    localparam logic signed [COUNTER_SIZE-1:0] C_MAX = {1'b0, {(COUNTER_SIZE-1){1'b1}}};
    localparam logic signed [COUNTER_SIZE-1:0] C_MIN = -C_MAX;
    localparam logic signed [COUNTER_SIZE-1:0] C_ONE = COUNTER_SIZE'(1);
    localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP);

    logic signed [COUNTER_SIZE-1:0] cnt_q [NUM_INPUTS];
    logic signed [COUNTER_SIZE-1:0] cnt_d [NUM_INPUTS];
    logic [SW-1:0] sel_q, sel_d;
    logic [WW-1:0] warm_q, warm_d;
    logic          valid_q, valid_d;
    logic          mode_q, mode_d;

    logic [SW-1:0]                  best_idx;
    logic signed [COUNTER_SIZE-1:0] best_val;

    // Strict comparison keeps the earlier (lower) index on ties.
    always_comb begin
        best_idx = '0;
        best_val = cnt_q[0];
        for (int i = 1; i < NUM_INPUTS; i++) begin
            if (mode_q ? (cnt_q[i] < best_val) : (cnt_q[i] > best_val)) begin
                best_idx = SW'(i);
                best_val = cnt_q[i];
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        warm_d  = warm_q;
        valid_d = valid_q;
        mode_d  = mode_q;
        if (find_min != mode_q) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_d[i] = '0;
            end
            sel_d   = '0;
            warm_d  = '0;
            valid_d = 1'b0;
            mode_d  = find_min;
        end else if (en) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (as_p[i] && !as_m[i] && (cnt_q[i] != C_MAX)) begin
                    cnt_d[i] = cnt_q[i] + C_ONE;
                end else if (as_m[i] && !as_p[i] && (cnt_q[i] != C_MIN)) begin
                    cnt_d[i] = cnt_q[i] - C_ONE;
                end
            end
            sel_d = best_idx;
            if (warm_q != WARM_MAX) begin
                warm_d = warm_q + WW'(1);
            end
            if (warm_d == WARM_MAX) begin
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
            sel_q   <= '0;
            warm_q  <= '0;
            valid_q <= 1'b0;
            mode_q  <= find_min;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            warm_q  <= warm_d;
            valid_q <= valid_d;
            mode_q  <= mode_d;
        end
    end

    assign y_p       = !RST && as_p[sel_q];
    assign y_m       = !RST && as_m[sel_q];
    assign sel_idx   = sel_q;
    assign out_valid = valid_q;

endmodule
